ff_input_cond: RTL and testbench
================================

# ff_input_cond

Front-end conditioner for the ten cabinet switch inputs that feed the foodfight core. Each raw switch is synchronized into the 12 MHz domain and debounced against a shared millisecond-scale tick. The three coin channels are optionally reshaped into fixed-width, rate-limited credit pulses. Outputs drive the core's test/throw/start/coin/centre inputs directly, in the same bit order as the board switch bus.

## Interface
Parameters:
- TICK_CYCLES, 12000: clk_12mhz cycles per debounce tick (1 ms).
- DB_TICKS, 8: consecutive mismatching ticks required to accept a new level.
- COIN_PULSE_TICKS, 50: coin pulse high time, in ticks.
- COIN_GAP_TICKS, 50: minimum low time after a coin pulse, in ticks.

Ports (one clock; reset is asynchronous and active-low):
- clk_12mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sw_raw  in  10  raw switches, 1 = closed. Bits: 0 test, 1 throw2, 2 throw1, 3 coinaux, 4 start2, 5 start1, 6 coin2, 7 coin1, 8 cntrr, 9 cntrl.
- sw_clean  out  10  conditioned switches to the core, same bit order.
- coin_evt  out  3  one-cycle credit strobe: [0] coinaux, [1] coin2, [2] coin1.

## Operation
- Synchronizer: two flops per bit; reset value 0.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps. Registered tick is 1 for one cycle per wrap. First tick occurs TICK_CYCLES cycles after reset release.
- Debounce, per bit, with held level db and counter cnt (width $clog2(DB_TICKS)+1):
  - sync == db: cnt <= 0.
  - mismatch, no tick: cnt holds.
  - mismatch, tick, cnt == DB_TICKS-1: db <= sync, cnt <= 0.
  - mismatch, tick, otherwise: cnt <= cnt+1.
- Non-coin bits: sw_clean = db.
- Coin shaper, one FSM per coin channel:
  - IDLE: on a db rising edge (db & ~db_prev) -> PULSE; load tick counter; coin_evt high for that cycle.
  - PULSE: output 1; after COIN_PULSE_TICKS ticks -> GAP.
  - GAP: output 0; after COIN_GAP_TICKS ticks -> WAIT_REL if db == 1, else IDLE.
  - WAIT_REL: output 0; when db == 0 -> IDLE.
  - Rising edges outside IDLE are ignored, so at most one credit per accepted press.
- Reset values: all sync flops, db, cnt, prescaler, sw_clean, coin_evt = 0; FSMs in IDLE.
- Asserting reset_n mid-debounce or mid-pulse clears all state immediately; outputs go to 0 asynchronously.
- Switches already closed at reset release are treated as new presses and are accepted after the debounce delay. For coin channels this yields one credit.

## Timing
- Raw edge to sync output: 2 cycles.
- Stable raw change to sw_clean change: between (DB_TICKS-1)*TICK_CYCLES+3 and DB_TICKS*TICK_CYCLES+3 cycles.
- Any bounce that returns the synchronized input to db before acceptance restarts the count.
- Coin pulse width: exactly COIN_PULSE_TICKS*TICK_CYCLES cycles, ±0 once the first tick is aligned. PULSE is entered mid-tick-period, so the first period may be partial: width is in [(COIN_PULSE_TICKS-1)*TICK_CYCLES+1, COIN_PULSE_TICKS*TICK_CYCLES].
- coin_evt rises on the same edge as the PULSE entry; sw_clean coin bit rises on that same edge.
- All outputs are registered; no combinational path from sw_raw.

## Configuration
- FF_COIN_SHAPE_EN defined: the coin FSMs are built as described above.
- FF_COIN_SHAPE_EN undefined: coin bits behave like every other bit (sw_clean = db); coin_evt is the one-cycle db rising-edge strobe, and the FSM logic is not built.

## Structure
- Shared package ff_pkg holds:
  - switch bit-index constants (SW_TEST .. SW_CNTRL);
  - the coin FSM state enum (IDLE, PULSE, GAP, WAIT_REL);
  - default tick and debounce constants.
- One sub-module, ff_debounce: one bit of synchronizer plus debounce, with tick as an input. It is instantiated ten times; the prescaler and coin FSMs live in ff_input_cond.

## Test plan
Bench parameters: TICK_CYCLES=10, DB_TICKS=4, COIN_PULSE_TICKS=5, COIN_GAP_TICKS=3, macro defined unless stated.
- Hold sw_raw=10'h3FF through reset -> sw_clean=0, coin_evt=0 during reset. After release, sw_clean[9] rises between cycle 33 and 43; coin_evt pulses once per coin channel.
- Toggle sw_raw[2] every 15 cycles for 200 cycles, then hold 1 -> sw_clean[2] stays 0 while toggling and rises ≤43 cycles after the final edge.
- Hold sw_raw[7]=1 for 500 cycles -> exactly one coin_evt[2] strobe; sw_clean[7] high 41–50 cycles then 0; no further pulse until release and re-press.
- Release and re-press sw_raw[6] during GAP -> single coin_evt[1], single pulse.
- Drop reset_n mid-PULSE -> sw_clean and coin_evt are 0 the same instant. After release with the switch open, no spurious pulse.
- Macro undefined, sw_raw[7]=1 held 500 cycles -> sw_clean[7] stays 1 from debounce acceptance to the end; one coin_evt[2] strobe.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared switch-bus indices, coin shaper state type and default timing constants
// for the foodfight cabinet input conditioner.
package ff_pkg;

    localparam int SW_TEST    = 0;
    localparam int SW_THROW2  = 1;
    localparam int SW_THROW1  = 2;
    localparam int SW_COINAUX = 3;
    localparam int SW_START2  = 4;
    localparam int SW_START1  = 5;
    localparam int SW_COIN2   = 6;
    localparam int SW_COIN1   = 7;
    localparam int SW_CNTRR   = 8;
    localparam int SW_CNTRL   = 9;
    localparam int SW_WIDTH   = 10;

    localparam int TICK_CYCLES_DEF      = 12000;
    localparam int DB_TICKS_DEF         = 8;
    localparam int COIN_PULSE_TICKS_DEF = 50;
    localparam int COIN_GAP_TICKS_DEF   = 50;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_e;

    // Coin channel order on coin_evt: [0] coinaux, [1] coin2, [2] coin1.
    function automatic int coin_bit(input int ch);
        case (ch)
            0:       return SW_COINAUX;
            1:       return SW_COIN2;
            default: return SW_COIN1;
        endcase
    endfunction

endpackage

// File: rtl/ff_debounce.sv
// One switch bit: two-flop synchronizer followed by a tick-counted debouncer.
module ff_debounce
    import ff_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk_12mhz,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic db
);
    localparam int CW = $clog2(DB_TICKS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/ff_input_cond.sv
// Cabinet switch conditioner: sync + debounce of ten switches, coin credit shaping.
// Coin pulse shaping is built only when FF_COIN_SHAPE_EN is defined.
//   state    | meaning
//   IDLE     | waiting for an accepted coin press
//   PULSE    | credit pulse high for COIN_PULSE_TICKS ticks
//   GAP      | forced low time of COIN_GAP_TICKS ticks
//   WAIT_REL | switch still closed after the gap, waiting for release
module ff_input_cond
    import ff_pkg::*;
#(
    parameter int TICK_CYCLES      = TICK_CYCLES_DEF,
    parameter int DB_TICKS         = DB_TICKS_DEF,
    parameter int COIN_PULSE_TICKS = COIN_PULSE_TICKS_DEF,
    parameter int COIN_GAP_TICKS   = COIN_GAP_TICKS_DEF
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic [9:0] sw_raw,
    output logic [9:0] sw_clean,
    output logic [2:0] coin_evt
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [9:0]    db;
    logic [2:0]    coin_db, coin_rise;
    logic [2:0]    coin_prev_q, coin_prev_d;
    logic [2:0]    coin_level, coin_strobe;
    logic [9:0]    sw_clean_q, sw_clean_d;
    logic [2:0]    coin_evt_q, coin_evt_d;

    always_comb begin
        tick_d = (pre_q == PRE_LAST);
        pre_d  = tick_d ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_db
        ff_debounce #(.DB_TICKS(DB_TICKS)) u_db (
            .clk_12mhz (clk_12mhz),
            .reset_n   (reset_n),
            .raw       (sw_raw[i]),
            .tick      (tick_q),
            .db        (db[i])
        );
    end

    assign coin_db     = {db[SW_COIN1], db[SW_COIN2], db[SW_COINAUX]};
    assign coin_prev_d = coin_db;
    assign coin_rise   = coin_db & ~coin_prev_q;

`ifdef FF_COIN_SHAPE_EN
    localparam int TMAX = (COIN_PULSE_TICKS > COIN_GAP_TICKS) ? COIN_PULSE_TICKS : COIN_GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE_TICKS);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(COIN_GAP_TICKS);
    localparam logic [TW-1:0] T_ONE      = TW'(1);

    for (genvar c = 0; c < 3; c++) begin : g_coin
        coin_state_e   state_q, state_d;
        logic [TW-1:0] tcnt_q, tcnt_d;
        logic          start;

        always_comb begin
            state_d = state_q;
            tcnt_d  = tcnt_q;
            start   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (coin_rise[c]) begin
                        state_d = PULSE;
                        tcnt_d  = PULSE_LOAD;
                        start   = 1'b1;
                    end
                end
                PULSE: begin
                    if (tick_q) begin
                        if (tcnt_q == T_ONE) begin
                            state_d = GAP;
                            tcnt_d  = GAP_LOAD;
                        end else begin
                            tcnt_d = tcnt_q - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick_q) begin
                        if (tcnt_q == T_ONE) begin
                            state_d = coin_db[c] ? WAIT_REL : IDLE;
                        end else begin
                            tcnt_d = tcnt_q - 1'b1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (!coin_db[c]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_12mhz or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                tcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                tcnt_q  <= tcnt_d;
            end
        end

        // Output taken from the next state so the level rises with the strobe.
        assign coin_level[c]  = (state_d == PULSE);
        assign coin_strobe[c] = start;
    end
`else
    logic [31:0] unused_coin_cfg;
    assign unused_coin_cfg = COIN_PULSE_TICKS + COIN_GAP_TICKS;
    assign coin_level      = coin_db;
    assign coin_strobe     = coin_rise;
`endif

    always_comb begin
        sw_clean_d             = db;
        sw_clean_d[SW_COINAUX] = coin_level[0];
        sw_clean_d[SW_COIN2]   = coin_level[1];
        sw_clean_d[SW_COIN1]   = coin_level[2];
        coin_evt_d             = coin_strobe;
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            pre_q       <= '0;
            tick_q      <= 1'b0;
            coin_prev_q <= '0;
            sw_clean_q  <= '0;
            coin_evt_q  <= '0;
        end else begin
            pre_q       <= pre_d;
            tick_q      <= tick_d;
            coin_prev_q <= coin_prev_d;
            sw_clean_q  <= sw_clean_d;
            coin_evt_q  <= coin_evt_d;
        end
    end

    assign sw_clean = sw_clean_q;
    assign coin_evt = coin_evt_q;

endmodule

// File: tb/tb_ff_input_cond.sv
// Self-checking bench for ff_input_cond: debounce windows, coin credits, async reset.
// Expectations follow FF_COIN_SHAPE_EN when it is defined for the build.
module tb_ff_input_cond;
    import ff_pkg::*;

    localparam int T  = 10;
    localparam int DB = 4;
    localparam int PT = 5;
    localparam int GT = 3;
    localparam int LAT_LO = (DB - 1) * T + 3;
    localparam int LAT_HI = DB * T + 3;
    localparam int W_LO   = (PT - 1) * T + 1;
    localparam int W_HI   = PT * T;

    logic       clk_12mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] sw_raw    = '0;
    logic [9:0] sw_clean;
    logic [2:0] coin_evt;

    ff_input_cond #(
        .TICK_CYCLES      (T),
        .DB_TICKS         (DB),
        .COIN_PULSE_TICKS (PT),
        .COIN_GAP_TICKS   (GT)
    ) dut (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .coin_evt  (coin_evt)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    int n_checks = 0;
    int n_fail   = 0;
    int q_exp[$];
    int evt_cnt[3];
    int rise_cnt[3];
    int cur_width[3];
    int last_width[3];
    int mon_e;
    logic [9:0] prev_clean = '0;
    logic [2:0] prev_evt   = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard side: every credit strobe must match the oldest expected channel.
    always @(negedge clk_12mhz) begin
        if (reset_n) begin
            for (int c = 0; c < 3; c++) begin
                if (coin_evt[c]) begin
                    evt_cnt[c]++;
                    if (q_exp.size() == 0) begin
                        check("unexpected_coin_evt", c, -1);
                    end else begin
                        mon_e = q_exp.pop_front();
                        check("coin_evt_channel", c, mon_e);
                    end
                    check("coin_evt_one_cycle", int'(prev_evt[c]), 0);
                    check("coin_evt_with_clean_rise",
                          int'({prev_clean[coin_bit(c)], sw_clean[coin_bit(c)]}), 1);
                end
                if (sw_clean[coin_bit(c)]) begin
                    if (!prev_clean[coin_bit(c)]) rise_cnt[c]++;
                    cur_width[c]++;
                end else if (prev_clean[coin_bit(c)]) begin
                    last_width[c] = cur_width[c];
                    cur_width[c]  = 0;
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) cur_width[c] = 0;
        end
        prev_clean = sw_clean;
        prev_evt   = coin_evt;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_12mhz);
        #1;
    endtask

    // Counts rising clock edges until sw_clean[bitn] reaches lvl; -1 if it never does.
    task automatic wait_level(input int bitn, input logic lvl, input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk_12mhz);
            @(negedge clk_12mhz);
            if (sw_clean[bitn] == lvl) begin
                lat = i;
                break;
            end
        end
        #1;
    endtask

    typedef struct {
        int bitn;
        int len;
        int acc;
    } vec_t;

    vec_t vt[6];
    int   lat;
    int   seen;
    int   e0;
    int   r0;

    initial begin
        vt[0] = '{SW_TEST,   15,  0};
        vt[1] = '{SW_THROW2, 25,  0};
        vt[2] = '{SW_START1, 60,  1};
        vt[3] = '{SW_CNTRR,  100, 1};
        vt[4] = '{SW_START2, 45,  1};
        vt[5] = '{SW_THROW1, 28,  0};
        for (int c = 0; c < 3; c++) begin
            evt_cnt[c] = 0; rise_cnt[c] = 0; cur_width[c] = 0; last_width[c] = 0;
        end

        // All switches closed through reset, then released from reset.
        sw_raw = '1;
        cyc(5);
        check("reset_sw_clean", int'(sw_clean), 0);
        check("reset_coin_evt", int'(coin_evt), 0);
        q_exp.push_back(0);
        q_exp.push_back(1);
        q_exp.push_back(2);
        @(negedge clk_12mhz);
        reset_n = 1'b1;
        wait_level(SW_CNTRL, 1'b1, 60, lat);
        check_rng("cntrl_accept_after_reset", lat, LAT_LO, LAT_HI);
        cyc(100);
        for (int c = 0; c < 3; c++) begin
            check("reset_press_credits", evt_cnt[c], 1);
            check("reset_press_rises", rise_cnt[c], 1);
`ifdef FF_COIN_SHAPE_EN
            check_rng("reset_press_width", last_width[c], W_LO, W_HI);
`endif
        end
`ifdef FF_COIN_SHAPE_EN
        check("all_closed_clean", int'(sw_clean), 10'h337);
`else
        check("all_closed_clean", int'(sw_clean), 10'h3FF);
`endif
        sw_raw = '0;
        cyc(100);
        check("all_open_clean", int'(sw_clean), 0);

        // Table: single presses of non-coin switches, short ones must be rejected.
        for (int k = 0; k < 6; k++) begin
            sw_raw[vt[k].bitn] = 1'b1;
            lat = -1;
            for (int i = 1; i <= vt[k].len; i++) begin
                @(posedge clk_12mhz);
                @(negedge clk_12mhz);
                if (lat < 0 && sw_clean[vt[k].bitn]) lat = i;
            end
            #1;
            check("tbl_accepted", int'(lat >= 0), vt[k].acc);
            if (vt[k].acc != 0) begin
                check_rng("tbl_rise_latency", lat, LAT_LO, LAT_HI);
                check("tbl_only_this_bit", int'(sw_clean), 1 << vt[k].bitn);
                sw_raw[vt[k].bitn] = 1'b0;
                wait_level(vt[k].bitn, 1'b0, 60, lat);
                check_rng("tbl_fall_latency", lat, LAT_LO, LAT_HI);
            end else begin
                sw_raw[vt[k].bitn] = 1'b0;
                cyc(50);
                check("tbl_rejected_clean", int'(sw_clean), 0);
            end
            cyc(10);
        end

        // Bouncing throw1: toggles every 15 cycles never reach acceptance.
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            sw_raw[SW_THROW1] = ~sw_raw[SW_THROW1];
            for (int i = 0; i < 15; i++) begin
                @(negedge clk_12mhz);
                if (sw_clean[SW_THROW1]) seen = 1;
            end
            #1;
        end
        check("bounce_never_accepted", seen, 0);
        sw_raw[SW_THROW1] = 1'b1;
        wait_level(SW_THROW1, 1'b1, 60, lat);
        check_rng("bounce_final_latency", lat, LAT_LO, LAT_HI);
        sw_raw[SW_THROW1] = 1'b0;
        cyc(60);

        // Coin1 held for 500 cycles: one credit; re-press after release gives another.
        e0 = evt_cnt[2];
        r0 = rise_cnt[2];
        q_exp.push_back(2);
        sw_raw[SW_COIN1] = 1'b1;
        cyc(500);
        check("hold_coin1_credits", evt_cnt[2] - e0, 1);
        check("hold_coin1_rises", rise_cnt[2] - r0, 1);
`ifdef FF_COIN_SHAPE_EN
        check_rng("hold_coin1_width", last_width[2], W_LO, W_HI);
        check("hold_coin1_level", int'(sw_clean[SW_COIN1]), 0);
`else
        check("hold_coin1_level", int'(sw_clean[SW_COIN1]), 1);
`endif
        sw_raw[SW_COIN1] = 1'b0;
        cyc(60);
        check("coin1_release_no_credit", evt_cnt[2] - e0, 1);
        q_exp.push_back(2);
        sw_raw[SW_COIN1] = 1'b1;
        cyc(100);
        check("coin1_repress_credit", evt_cnt[2] - e0, 2);
        sw_raw[SW_COIN1] = 1'b0;
        cyc(100);

        // Coin2 short release/re-press inside the gap after its pulse.
        e0 = evt_cnt[1];
        r0 = rise_cnt[1];
        q_exp.push_back(1);
        sw_raw[SW_COIN2] = 1'b1;
        wait_level(SW_COIN2, 1'b1, 60, lat);
        check_rng("coin2_accept_latency", lat, LAT_LO, LAT_HI);
        cyc(54);
        sw_raw[SW_COIN2] = 1'b0;
        cyc(12);
        sw_raw[SW_COIN2] = 1'b1;
        cyc(100);
        check("gap_repress_credits", evt_cnt[1] - e0, 1);
        check("gap_repress_rises", rise_cnt[1] - r0, 1);
`ifdef FF_COIN_SHAPE_EN
        check_rng("gap_repress_width", last_width[1], W_LO, W_HI);
        check("gap_repress_level", int'(sw_clean[SW_COIN2]), 0);
`else
        check("gap_repress_level", int'(sw_clean[SW_COIN2]), 1);
`endif
        sw_raw[SW_COIN2] = 1'b0;
        cyc(100);

        // Reset asserted while coin1 output is high.
        q_exp.push_back(2);
        sw_raw[SW_COIN1] = 1'b1;
        wait_level(SW_COIN1, 1'b1, 60, lat);
        check_rng("coin1_pre_reset_latency", lat, LAT_LO, LAT_HI);
        cyc(10);
        check("coin1_high_before_reset", int'(sw_clean[SW_COIN1]), 1);
        sw_raw[SW_COIN1] = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midpulse_reset_clean", int'(sw_clean), 0);
        check("midpulse_reset_evt", int'(coin_evt), 0);
        e0 = evt_cnt[2];
        cyc(3);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_12mhz);
            if (sw_clean != 10'h000 || coin_evt != 3'b000) seen = 1;
        end
        #1;
        check("post_reset_quiet", seen, 0);
        check("post_reset_no_credit", evt_cnt[2] - e0, 0);
        check("scoreboard_drained", q_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
